// File: rtl/rx_ber_checker.sv
// Decimating slicer followed by a self-synchronising PRBS9 checker with lock monitor
// and saturating bit/error counters for BER measurement.
module rx_ber_checker #(
  parameter int UPSAMPLE  = 4,
  parameter int IN_NBITS  = 8,
  parameter int CNT_NBITS = 32,
  parameter int WIN_LEN   = 128,
  parameter int LOSS_THR  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [IN_NBITS-1:0]    rx_in,
  input  logic [$clog2(UPSAMPLE)-1:0]   phase,
  input  logic                          clear,
  output logic                          rx_bit,
  output logic                          rx_bit_vld,
  output logic                          locked,
  output logic [CNT_NBITS-1:0]          ber_bits,
  output logic [CNT_NBITS-1:0]          ber_errors
);

  localparam int PH_W = $clog2(UPSAMPLE);
  localparam int WC_W = $clog2(WIN_LEN + 1);

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic                 rx_bit_q, rx_bit_d;
  logic                 vld_q, vld_d;
  logic [8:0]           prbs_q, prbs_d;
  logic [3:0]           fill_q, fill_d;
  logic [WC_W-1:0]      win_cnt_q, win_cnt_d;
  logic [WC_W-1:0]      win_err_q, win_err_d;
  logic [CNT_NBITS-1:0] bits_q, bits_d;
  logic [CNT_NBITS-1:0] errs_q, errs_d;

  logic                 pred;
  logic                 mism;
  logic                 cnt_inc;
  logic [WC_W-1:0]      win_cnt_nxt;
  logic [WC_W-1:0]      win_err_nxt;

  always_comb begin
    samp_cnt_d  = samp_cnt_q;
    rx_bit_d    = rx_bit_q;
    vld_d       = 1'b0;
    state_d     = state_q;
    prbs_d      = prbs_q;
    fill_d      = fill_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bits_d      = bits_q;
    errs_d      = errs_q;
    cnt_inc     = 1'b0;
    win_cnt_nxt = win_cnt_q + WC_W'(1);
    win_err_nxt = win_err_q;
    pred        = prbs_q[8] ^ prbs_q[4];
    mism        = rx_bit_q ^ pred;

    if (enable) begin
      samp_cnt_d = (samp_cnt_q == PH_W'(UPSAMPLE - 1)) ? '0 : samp_cnt_q + PH_W'(1);
      if (samp_cnt_q == phase) begin
        rx_bit_d = ~rx_in[IN_NBITS-1];
        vld_d    = 1'b1;
      end
    end

    // The FSM consumes the bit registered on the previous cycle.
    if (vld_q) begin
      unique case (state_q)
        SYNC: begin
          prbs_d = {prbs_q[7:0], rx_bit_q};
          if (fill_q == 4'd8) begin
            state_d   = CHECK;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        CHECK: begin
          prbs_d      = {prbs_q[7:0], pred};
          cnt_inc     = 1'b1;
          win_err_nxt = win_err_q + WC_W'(mism);
          if (win_cnt_nxt == WC_W'(WIN_LEN)) begin
            if (win_err_nxt > WC_W'(LOSS_THR)) begin
              state_d = SYNC;
              fill_d  = '0;
            end
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_nxt;
            win_err_d = win_err_nxt;
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (clear) begin
      bits_d = '0;
      errs_d = '0;
    end else if (cnt_inc && (bits_q != '1)) begin
      bits_d = bits_q + CNT_NBITS'(1);
      errs_d = errs_q + CNT_NBITS'(mism);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC;
      samp_cnt_q <= '0;
      rx_bit_q   <= 1'b0;
      vld_q      <= 1'b0;
      prbs_q     <= '0;
      fill_q     <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      bits_q     <= '0;
      errs_q     <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      rx_bit_q   <= rx_bit_d;
      vld_q      <= vld_d;
      prbs_q     <= prbs_d;
      fill_q     <= fill_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      bits_q     <= bits_d;
      errs_q     <= errs_d;
    end
  end

  assign rx_bit     = rx_bit_q;
  assign rx_bit_vld = vld_q;
  assign locked     = (state_q == CHECK);
  assign ber_bits   = bits_q;
  assign ber_errors = errs_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Bench for rx_ber_checker: sequence-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations. A 4-bit-counter instance shares stimulus.
module tb_rx_ber_checker;

  localparam int UPS      = 4;
  localparam int WIN_LEN  = 128;
  localparam int LOSS_THR = 16;
  localparam longint BIG_MAX   = 64'hFFFF_FFFF;
  localparam longint SMALL_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic signed [7:0] rx_in = 8'sd0;
  logic [1:0]        phase = 2'd2;
  logic              clear = 1'b0;

  logic        rx_bit, rx_bit_vld, locked;
  logic [31:0] ber_bits, ber_errors;
  logic        rx_bit2, rx_bit_vld2, locked2;
  logic [3:0]  ber_bits2, ber_errors2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int vld_cnt  = 0;
  int ones_cnt = 0;
  int sym_idx  = 0;
  bit tx_h[$];

  rx_ber_checker #(.UPSAMPLE(UPS), .IN_NBITS(8), .CNT_NBITS(32),
                   .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_in(rx_in), .phase(phase), .clear(clear),
    .rx_bit(rx_bit), .rx_bit_vld(rx_bit_vld), .locked(locked),
    .ber_bits(ber_bits), .ber_errors(ber_errors));

  rx_ber_checker #(.UPSAMPLE(UPS), .IN_NBITS(8), .CNT_NBITS(4),
                   .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) dut_small (
    .clk(clk), .rst(rst), .enable(enable), .rx_in(rx_in), .phase(phase), .clear(clear),
    .rx_bit(rx_bit2), .rx_bit_vld(rx_bit_vld2), .locked(locked2),
    .ber_bits(ber_bits2), .ber_errors(ber_errors2));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs after each rising edge.
  int     m_cnt = 0;
  bit     m_vld = 0, m_bit = 0, m_locked = 0;
  bit     sync_q[$];
  bit     local_q[$];
  int     wbits = 0, werr = 0;
  longint m_bits = 0, m_errs = 0, s_bits = 0, s_errs = 0;

  always @(posedge clk) begin : model
    bit chk, err, p;
    chk = 0;
    err = 0;
    p   = 0;
    if (rst) begin
      m_cnt = 0; m_vld = 0; m_bit = 0; m_locked = 0;
      sync_q.delete(); local_q.delete();
      wbits = 0; werr = 0;
      m_bits = 0; m_errs = 0; s_bits = 0; s_errs = 0;
    end else begin
      if (m_vld) begin
        if (!m_locked) begin
          sync_q.push_back(m_bit);
          if (sync_q.size() == 9) begin
            m_locked = 1;
            local_q  = sync_q;
            sync_q.delete();
            wbits = 0;
            werr  = 0;
          end
        end else begin
          p = local_q[0] ^ local_q[4];
          void'(local_q.pop_front());
          local_q.push_back(p);
          chk = 1;
          err = (m_bit != p);
          wbits++;
          werr += int'(err);
          if (wbits == WIN_LEN) begin
            if (werr > LOSS_THR) m_locked = 0;
            wbits = 0;
            werr  = 0;
          end
        end
      end
      if (clear) begin
        m_bits = 0; m_errs = 0; s_bits = 0; s_errs = 0;
      end else if (chk) begin
        if (m_bits != BIG_MAX) begin m_bits++; m_errs += longint'(err); end
        if (s_bits != SMALL_MAX) begin s_bits++; s_errs += longint'(err); end
      end
      m_vld = enable && (m_cnt == int'(phase));
      if (m_vld) m_bit = (rx_in >= 0);
      if (enable) m_cnt = (m_cnt + 1) % UPS;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_bit_vld", longint'(rx_bit_vld), longint'(m_vld));
      if (m_vld) check("rx_bit", longint'(rx_bit), longint'(m_bit));
      check("locked", longint'(locked), longint'(m_locked));
      check("ber_bits", longint'(ber_bits), m_bits);
      check("ber_errors", longint'(ber_errors), m_errs);
      check("small_locked", longint'(locked2), longint'(m_locked));
      check("small_ber_bits", longint'(ber_bits2), s_bits);
      check("small_ber_errors", longint'(ber_errors2), s_errs);
    end
    if (rx_bit_vld) begin
      vld_cnt++;
      if (rx_bit) ones_cnt++;
    end
  end

  task automatic drive_cycle(input bit en, input logic signed [7:0] v);
    enable = en;
    rx_in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 8'sd0);
  endtask

  task automatic send_sym(input bit b, input bit inv);
    logic signed [7:0] v;
    for (int k = 0; k < UPS; k++) begin
      if (b ^ inv) v = (k == 2) ? ((sym_idx % 3 == 0) ? 8'sd0 : 8'sd127) : 8'sd60;
      else         v = (k == 2) ? ((sym_idx % 2 == 0) ? 8'sh80 : -8'sd1) : -8'sd60;
      drive_cycle(1'b1, v);
    end
    sym_idx++;
  endtask

  task automatic send_prbs(input int n, input int inv_lo, input int inv_hi);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = tx_h[0] ^ tx_h[4];
      void'(tx_h.pop_front());
      tx_h.push_back(b);
      send_sym(b, (i >= inv_lo) && (i <= inv_hi));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) drive_cycle(1'b1, 8'sd33);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("rst_locked", longint'(locked), 0);
    check("rst_vld", longint'(rx_bit_vld), 0);
    check("rst_bits", longint'(ber_bits), 0);
    check("rst_errors", longint'(ber_errors), 0);
  endtask

  task automatic lit(input string name, input longint act, input longint exp);
    @(negedge clk);
    check(name, act, exp);
  endtask

  logic signed [7:0] pat [4];

  initial begin
    tx_h = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pat  = '{-8'sd5, -8'sd5, 8'sd7, -8'sd5};
    drive_cycle(1'b1, 8'sd0);
    chk_en = 1'b1;
    do_reset();

    // Phase selection
    phase = 2'd2; vld_cnt = 0; ones_cnt = 0;
    repeat (8) for (int k = 0; k < UPS; k++) drive_cycle(1'b1, pat[k]);
    idle(2);
    lit("ph2_vld_count", longint'(vld_cnt), 8);
    lit("ph2_ones", longint'(ones_cnt), 8);
    phase = 2'd0; vld_cnt = 0; ones_cnt = 0;
    repeat (8) for (int k = 0; k < UPS; k++) drive_cycle(1'b1, pat[k]);
    idle(2);
    lit("ph0_vld_count", longint'(vld_cnt), 8);
    lit("ph0_ones", longint'(ones_cnt), 0);

    // Reset mid-stream, then lock on PRBS9
    do_reset();
    phase = 2'd2;
    send_prbs(8, -1, -1);
    idle(2);
    lit("lock_after8", longint'(locked), 0);
    send_prbs(1, -1, -1);
    idle(2);
    lit("lock_after9", longint'(locked), 1);
    lit("bits_at_lock", longint'(ber_bits), 0);
    send_prbs(1000, -1, -1);
    idle(2);
    lit("bits_1000", longint'(ber_bits), 1000);
    lit("errs_1000", longint'(ber_errors), 0);
    lit("small_sat", longint'(ber_bits2), 15);

    // Single error
    send_prbs(21, 0, 0);
    idle(2);
    lit("single_err", longint'(ber_errors), 1);
    lit("single_bits", longint'(ber_bits), 1021);
    lit("single_locked", longint'(locked), 1);

    // Window loss threshold, last bit of window inverted in both cases
    do_reset();
    send_prbs(9, -1, -1);
    send_prbs(WIN_LEN, 112, 127);
    idle(2);
    lit("thr16_locked", longint'(locked), 1);
    lit("thr16_errs", longint'(ber_errors), 16);
    send_prbs(WIN_LEN, 111, 127);
    idle(2);
    lit("thr17_locked", longint'(locked), 0);
    lit("thr17_errs", longint'(ber_errors), 33);
    lit("thr17_bits", longint'(ber_bits), 256);
    send_prbs(8, -1, -1);
    idle(2);
    lit("relock_8", longint'(locked), 0);
    send_prbs(1, -1, -1);
    idle(2);
    lit("relock_9", longint'(locked), 1);
    send_prbs(20, -1, -1);
    idle(2);
    lit("relock_errs", longint'(ber_errors), 33);
    lit("relock_bits", longint'(ber_bits), 276);

    // Saturation on the 4-bit instance and clear vs simultaneous error
    do_reset();
    send_prbs(9, -1, -1);
    send_prbs(3, 2, 2);
    send_prbs(3, 2, 2);
    send_prbs(14, 11, 11);
    idle(2);
    lit("sat_bits", longint'(ber_bits2), 15);
    lit("sat_errs", longint'(ber_errors2), 2);
    lit("wide_bits", longint'(ber_bits), 20);
    lit("wide_errs", longint'(ber_errors), 3);
    clear = 1'b1;
    send_prbs(1, 0, 0);
    clear = 1'b0;
    idle(1);
    lit("clr_bits", longint'(ber_bits), 0);
    lit("clr_errs", longint'(ber_errors), 0);
    lit("clr_small_bits", longint'(ber_bits2), 0);
    lit("clr_small_errs", longint'(ber_errors2), 0);
    lit("clr_locked", longint'(locked), 1);
    send_prbs(1, -1, -1);
    idle(2);
    lit("post_clr_bits", longint'(ber_bits), 1);
    lit("post_clr_errs", longint'(ber_errors), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
